counter: RTL and testbench

- Synchronous up-counter with parallel load, hold, and asynchronous active-low clear.
- Serves as the pixel/line position counter in the VGA controller datapath; two instances (horizontal and vertical) sit under the VGA timing block.
- Q is a registered output with no combinational path from D, Count, or Load.

---
 rtl/counter.sv | 40 ++++
 tb/tb_counter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/counter.sv
// rtl/counter.sv - up-counter with parallel load, hold and async active-low clear
// Optional feature macro: COUNTER_SATURATE_EN (saturate at MAX_VALUE instead of wrapping)
module counter #(
  parameter int WIDTH     = 10,
  parameter int MAX_VALUE = 2**WIDTH-1
) (
  input  logic             Count,
  input  logic             Load,
  input  logic             Clear,
  input  logic             Clock,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic             at_max;
  logic [WIDTH-1:0] top_next;

  // Loaded values above MAX_VALUE are treated like MAX_VALUE on the next count.
  assign at_max = (Q >= MAX_Q);

`ifdef COUNTER_SATURATE_EN
  assign top_next = Q;
`else
  assign top_next = '0;
`endif

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      Q <= '0;
    end else if (Load) begin
      Q <= D;
    end else if (Count) begin
      Q <= at_max ? top_next : Q + ONE;
    end
  end

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - self-checking bench for counter: vector table, corner sequences, random vs model
module tb_counter;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       Count, Load, Clear, Clock;
  logic [9:0] D;
  logic [9:0] Q, q799;

  int checks = 0;
  int errors = 0;
  int m1 = 0;
  int m2 = 0;

  counter #(.WIDTH(10)) dut (
    .Count(Count), .Load(Load), .Clear(Clear), .Clock(Clock), .D(D), .Q(Q)
  );

  counter #(.WIDTH(10), .MAX_VALUE(799)) dut799 (
    .Count(Count), .Load(Load), .Clear(Clear), .Clock(Clock), .D(D), .Q(q799)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    bit       clear;
    bit       load;
    bit       count;
    bit [9:0] d;
    int       exp_q;
  } vec_t;

  vec_t vecs[$];

  function automatic int model_next(int q, bit ld, bit ct, int d, int mx);
    if (ld) return d;
    if (!ct) return q;
    if (q < mx) return q + 1;
    return SAT ? q : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One rising edge: advance the reference models, then sample 1ns after the edge.
  task automatic step();
    if (!Clear) begin
      m1 = 0;
      m2 = 0;
    end else begin
      m1 = model_next(m1, Load, Count, int'(D), 1023);
      m2 = model_next(m2, Load, Count, int'(D), 799);
    end
    @(posedge Clock);
    #1;
    check("max799_model", int'(q799), m2);
  endtask

  task automatic async_clear();
    @(negedge Clock);
    Clear = 1'b0;
    m1 = 0;
    m2 = 0;
    #1;
    check("async_clear_q", int'(Q), 0);
    check("async_clear_q799", int'(q799), 0);
  endtask

  function automatic vec_t mk(bit c, bit l, bit n, bit [9:0] d, int e);
    vec_t v;
    v.clear = c; v.load = l; v.count = n; v.d = d; v.exp_q = e;
    return v;
  endfunction

  initial begin
    Count = 1'b0; Load = 1'b0; D = '0; Clear = 1'b1;
    #1 Clear = 1'b0;
    #1 check("reset_q", int'(Q), 0);

    vecs.push_back(mk(0, 1, 0, 10'h1A8, 0));
    vecs.push_back(mk(0, 1, 1, 10'h1A8, 0));
    vecs.push_back(mk(1, 1, 0, 10'h1A8, 424));
    vecs.push_back(mk(1, 0, 1, 10'h1A8, 425));
    vecs.push_back(mk(1, 0, 1, 10'h1A8, 426));
    vecs.push_back(mk(1, 0, 1, 10'h1A8, 427));
    vecs.push_back(mk(1, 0, 0, 10'h1A8, 427));
    vecs.push_back(mk(1, 0, 0, 10'h1AB, 427));
    vecs.push_back(mk(1, 1, 1, 10'h1AB, 10'h1AB));
    vecs.push_back(mk(1, 1, 1, 10'h1AB, 10'h1AB));
    vecs.push_back(mk(1, 1, 0, 10'h3FE, 10'h3FE));
    vecs.push_back(mk(1, 0, 1, 10'h3FE, 10'h3FF));
    vecs.push_back(mk(1, 0, 1, 10'h000, SAT ? 10'h3FF : 0));
    vecs.push_back(mk(1, 0, 1, 10'h000, SAT ? 10'h3FF : 1));
    vecs.push_back(mk(1, 1, 0, 10'd798, 798));
    vecs.push_back(mk(1, 0, 1, 10'd5, 799));

    foreach (vecs[i]) begin
      Clear = vecs[i].clear;
      Load  = vecs[i].load;
      Count = vecs[i].count;
      D     = vecs[i].d;
      step();
      check($sformatf("vec%0d_q", i), int'(Q), vecs[i].exp_q);
    end

    // Clear mid-count: zero immediately, held across an edge, then counting resumes from 0.
    Load = 1'b0; Count = 1'b1;
    step();
    async_clear();
    step();
    check("clear_hold_q", int'(Q), 0);
    @(negedge Clock);
    Clear = 1'b1;
    step();
    check("resume_q1", int'(Q), 1);
    step();
    check("resume_q2", int'(Q), 2);

    // Value above 799 loaded into the 799 instance must wrap or stick on the next count.
    Load = 1'b1; D = 10'd900;
    step();
    Load = 1'b0; Count = 1'b1;
    step();
    check("above_max_q799", int'(q799), SAT ? 900 : 0);

    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        async_clear();
        step();
        check("rand_clear_hold", int'(Q), 0);
        @(negedge Clock);
        Clear = 1'b1;
      end
      Load  = ($urandom_range(0, 9) == 0);
      Count = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: D = 10'd797;
        1: D = 10'd1021;
        default: D = 10'($urandom);
      endcase
      step();
      check("rand_q", int'(Q), m1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
